// File: rtl/udp_order_frame_builder.sv
// Buffers 32-bit order words and emits Ethernet/IPv4/UDP frames on an 8-bit AXI-Stream master.
// Optional macro FRAME_SEQ_EN: header bytes 40..41 carry the frame sequence number.
module udp_order_frame_builder #(
  parameter int          FIFO_DEPTH    = 32,
  parameter int          MAX_ORDERS    = 16,
  parameter int          FLUSH_TIMEOUT = 1000,
  parameter logic [31:0] DEST_IP       = 32'hC0A80132,
  parameter logic [15:0] SRC_PORT      = 16'd55555,
  parameter logic [23:0] OP_MARKET     = 24'h102030,
  parameter logic [23:0] OP_DUMP       = 24'hF0E0D0
) (
  input  logic                          clk_udp,
  input  logic                          rst_udp,
  input  logic [31:0]                   s_order_tdata,
  input  logic                          s_order_tvalid,
  output logic                          s_order_tready,
  input  logic                          dump_req,
  input  logic                          flush_req,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   frames_sent
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMO_W = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(FLUSH_TIMEOUT);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_MAXO = LVL_W'(MAX_ORDERS);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_OPC     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_PAD     = 3'd4;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             r_in_ready;
  logic [2:0]       r_state;
  logic [5:0]       r_idx;
  logic [LVL_W-1:0] r_ord_left;
  logic             r_is_dump;
  logic             r_pend_dump;
  logic [TMO_W-1:0] r_tmo;
  logic [15:0]      r_frames;

  logic             w_push;
  logic             w_pop;
  logic             w_hs;
  logic             w_last;
  logic             w_trig_mkt;
  logic [LVL_W-1:0] w_n;
  logic [LVL_W-1:0] w_level_next;
  logic [31:0]      w_ord;
  logic [23:0]      w_opc;
  logic [7:0]       w_hdr_byte;
  logic [7:0]       w_opc_byte;
  logic [7:0]       w_ord_byte;

  assign w_push = s_order_tvalid & r_in_ready;
  assign w_hs   = (r_state != S_IDLE) & m_axis_tready;
  assign w_last = (r_state == S_PAD) |
                  ((r_state == S_PAYLOAD) & (r_idx[1:0] == 2'd3) & (r_ord_left == LVL_W'(1)));
  assign w_pop  = w_hs & (r_state == S_PAYLOAD) & (r_idx[1:0] == 2'd3);

  assign w_trig_mkt = (r_level >= LVL_MAXO) |
                      ((FLUSH_TIMEOUT != 0) && (r_tmo == TMO_MAX) && (r_level != '0)) |
                      (flush_req & (r_level != '0));
  assign w_n = (r_level >= LVL_MAXO) ? LVL_MAXO : r_level;

  always_comb begin
    w_level_next = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_next = r_level + LVL_W'(1);
      2'b01:   w_level_next = r_level - LVL_W'(1);
      default: w_level_next = r_level;
    endcase
  end

  always_ff @(posedge clk_udp) begin
    if (w_push) r_mem[r_wr_ptr] <= s_order_tdata;
  end

  always_ff @(posedge clk_udp) begin
    if (rst_udp) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_in_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level    <= w_level_next;
      r_in_ready <= (w_level_next != LVL_FULL);
    end
  end

  // Idle-age counter: only runs while orders sit in the FIFO with the FSM idle.
  always_ff @(posedge clk_udp) begin
    if (rst_udp || r_state != S_IDLE || r_level == '0) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_MAX) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end

  // A new request arriving as a dump frame starts is kept, yielding another dump.
  always_ff @(posedge clk_udp) begin
    if (rst_udp) begin
      r_pend_dump <= 1'b0;
    end else if (dump_req) begin
      r_pend_dump <= 1'b1;
    end else if (r_state == S_IDLE && !w_trig_mkt && r_pend_dump) begin
      r_pend_dump <= 1'b0;
    end
  end

  always_ff @(posedge clk_udp) begin
    if (rst_udp) begin
      r_frames <= '0;
    end else if (w_hs && w_last) begin
      r_frames <= r_frames + 16'd1;
    end
  end

  always_ff @(posedge clk_udp) begin
    if (rst_udp) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_ord_left <= '0;
      r_is_dump  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (w_trig_mkt) begin
            r_state    <= S_HDR;
            r_is_dump  <= 1'b0;
            r_ord_left <= w_n;
          end else if (r_pend_dump) begin
            r_state    <= S_HDR;
            r_is_dump  <= 1'b1;
            r_ord_left <= '0;
          end
        end
        S_HDR: if (w_hs) begin
          if (r_idx == 6'd41) begin
            r_state <= S_OPC;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        S_OPC: if (w_hs) begin
          if (r_idx == 6'd2) begin
            r_state <= r_is_dump ? S_PAD : S_PAYLOAD;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        S_PAYLOAD: if (w_hs) begin
          if (r_idx[1:0] == 2'd3) begin
            r_idx      <= '0;
            r_ord_left <= r_ord_left - LVL_W'(1);
            if (w_last) r_state <= S_IDLE;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
        S_PAD: if (w_hs) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_hdr_byte = 8'hAA;
    case (r_idx)
      6'd12: w_hdr_byte = 8'h08;
      6'd13: w_hdr_byte = 8'h00;
      6'd23: w_hdr_byte = 8'h11;
      6'd30: w_hdr_byte = DEST_IP[31:24];
      6'd31: w_hdr_byte = DEST_IP[23:16];
      6'd32: w_hdr_byte = DEST_IP[15:8];
      6'd33: w_hdr_byte = DEST_IP[7:0];
      6'd34: w_hdr_byte = SRC_PORT[15:8];
      6'd35: w_hdr_byte = SRC_PORT[7:0];
`ifdef FRAME_SEQ_EN
      // Completed-frame count since reset doubles as the sequence number.
      6'd40: w_hdr_byte = r_frames[15:8];
      6'd41: w_hdr_byte = r_frames[7:0];
`endif
      default: w_hdr_byte = 8'hAA;
    endcase
  end

  assign w_opc = r_is_dump ? OP_DUMP : OP_MARKET;
  assign w_ord = r_mem[r_rd_ptr];

  always_comb begin
    w_opc_byte = w_opc[7:0];
    w_ord_byte = w_ord[7:0];
    case (r_idx[1:0])
      2'd0: begin w_opc_byte = w_opc[23:16]; w_ord_byte = w_ord[31:24]; end
      2'd1: begin w_opc_byte = w_opc[15:8];  w_ord_byte = w_ord[23:16]; end
      2'd2: begin w_opc_byte = w_opc[7:0];   w_ord_byte = w_ord[15:8];  end
      default: begin w_opc_byte = w_opc[7:0]; w_ord_byte = w_ord[7:0]; end
    endcase
  end

  always_comb begin
    m_axis_tdata = 8'h00;
    case (r_state)
      S_HDR:     m_axis_tdata = w_hdr_byte;
      S_OPC:     m_axis_tdata = w_opc_byte;
      S_PAYLOAD: m_axis_tdata = w_ord_byte;
      default:   m_axis_tdata = 8'h00;
    endcase
  end

  assign m_axis_tvalid  = (r_state != S_IDLE);
  assign m_axis_tlast   = w_last;
  assign busy           = (r_state != S_IDLE);
  assign s_order_tready = r_in_ready;
  assign fifo_level     = r_level;
  assign frames_sent    = r_frames;

endmodule

// File: tb/tb_udp_order_frame_builder.sv
// Directed bench for udp_order_frame_builder: scoreboard of expected stream bytes, checked on every handshake.
module tb_udp_order_frame_builder;

  logic        clk_udp = 1'b0;
  logic        rst_udp;
  logic [31:0] s_order_tdata;
  logic        s_order_tvalid;
  logic        s_order_tready;
  logic        dump_req;
  logic        flush_req;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;
  logic        busy;
  logic [4:0]  fifo_level;
  logic [15:0] frames_sent;

  always #5 clk_udp = ~clk_udp;

  udp_order_frame_builder #(
    .FIFO_DEPTH(16), .MAX_ORDERS(4), .FLUSH_TIMEOUT(20)
  ) dut (
    .clk_udp(clk_udp), .rst_udp(rst_udp),
    .s_order_tdata(s_order_tdata), .s_order_tvalid(s_order_tvalid), .s_order_tready(s_order_tready),
    .dump_req(dump_req), .flush_req(flush_req),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .busy(busy), .fifo_level(fifo_level), .frames_sent(frames_sent)
  );

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  int          len_q[$];
  int          frames_obs = 0;
  int          model_frames = 0;
  logic        bp_en = 1'b0;
  logic        mon_quiet = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_udp);
    #1;
  endtask

  function automatic logic [7:0] hdr_byte(input int i, input int seq);
    logic [31:0] ip;
    logic [15:0] sp;
    logic [15:0] sq;
    ip = 32'hC0A80132;
    sp = 16'd55555;
    sq = seq[15:0];
    if (i == 12) return 8'h08;
    if (i == 13) return 8'h00;
    if (i == 23) return 8'h11;
    if (i >= 30 && i <= 33) return ip[8*(33-i) +: 8];
    if (i == 34 || i == 35) return sp[8*(35-i) +: 8];
`ifdef FRAME_SEQ_EN
    if (i == 40 || i == 41) return sq[8*(41-i) +: 8];
`endif
    return 8'hAA;
  endfunction

  task automatic push_hdr();
    for (int i = 0; i < 42; i++) exp_q.push_back({1'b0, hdr_byte(i, model_frames)});
  endtask

  task automatic push_market(input logic [31:0] ords[$]);
    push_hdr();
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b0, 8'h20});
    exp_q.push_back({1'b0, 8'h30});
    for (int k = 0; k < ords.size(); k++) begin
      logic [31:0] o;
      o = ords[k];
      exp_q.push_back({1'b0, o[31:24]});
      exp_q.push_back({1'b0, o[23:16]});
      exp_q.push_back({1'b0, o[15:8]});
      exp_q.push_back({k == ords.size() - 1, o[7:0]});
    end
    model_frames++;
  endtask

  task automatic push_dump();
    push_hdr();
    exp_q.push_back({1'b0, 8'hF0});
    exp_q.push_back({1'b0, 8'hE0});
    exp_q.push_back({1'b0, 8'hD0});
    exp_q.push_back({1'b1, 8'h00});
    model_frames++;
  endtask

  task automatic write_order(input logic [31:0] w);
    int k;
    s_order_tdata  = w;
    s_order_tvalid = 1'b1;
    k = 0;
    while (!s_order_tready && k < 100) begin tick(); k++; end
    tick();
    s_order_tvalid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int k;
    k = 0;
    while (frames_obs < target && k < 3000) begin tick(); k++; end
    chk("frame_wait", 32'(frames_obs >= target), 32'd1);
  endtask

  task automatic chk_len(input int exp);
    int v;
    v = (len_q.size() > 0) ? len_q.pop_front() : -1;
    chk("frame_len", v, exp);
  endtask

  // Random backpressure driver
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk_udp);
      #1;
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard compare, stall stability, no intra-frame gaps, gap after tlast
  initial begin
    logic       in_frame, prev_stall, prev_last;
    logic [7:0] prev_d;
    logic       prev_l;
    logic [8:0] e;
    int         cur_len;
    in_frame = 0; prev_stall = 0; prev_last = 0; prev_d = 0; prev_l = 0; cur_len = 0;
    forever begin
      @(negedge clk_udp);
      if (rst_udp || mon_quiet) begin
        in_frame = 0; prev_stall = 0; prev_last = 0; cur_len = 0;
      end else begin
        if (prev_last) chk("gap_after_tlast", m_axis_tvalid, 1'b0);
        if (in_frame)  chk("tvalid_held", m_axis_tvalid, 1'b1);
        if (prev_stall) begin
          chk("stall_tdata", m_axis_tdata, prev_d);
          chk("stall_tlast", m_axis_tlast, prev_l);
        end
        prev_last = 0;
        prev_stall = 0;
        if (m_axis_tvalid) begin
          in_frame = 1;
          if (m_axis_tready) begin
            if (exp_q.size() == 0) begin
              chk("sb_underflow", exp_q.size(), 32'd1);
            end else begin
              e = exp_q.pop_front();
              chk($sformatf("byte%0d", cur_len), {m_axis_tlast, m_axis_tdata}, e);
            end
            cur_len++;
            if (m_axis_tlast) begin
              len_q.push_back(cur_len);
              cur_len = 0;
              frames_obs++;
              in_frame = 0;
              prev_last = 1;
            end
          end else begin
            prev_stall = 1;
            prev_d = m_axis_tdata;
            prev_l = m_axis_tlast;
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] ords[$];
    logic [31:0] bp_ords[10];
    int          k;
    int          target;

    rst_udp = 1'b1; s_order_tdata = '0; s_order_tvalid = 1'b0; dump_req = 1'b0; flush_req = 1'b0;
    repeat (3) tick();
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tdata", m_axis_tdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_level", fifo_level, 5'd0);
    chk("rst_frames", frames_sent, 16'd0);
    chk("rst_sready", s_order_tready, 1'b0);
    rst_udp = 1'b0;
    tick();
    chk("sready_after_rst", s_order_tready, 1'b1);

    // Full batch of MAX_ORDERS triggers a frame
    ords = '{32'h0069000A, 32'h00648000, 32'h0066000A, 32'h006C000A};
    push_market(ords);
    foreach (ords[i]) write_order(ords[i]);
    wait_frames(1);
    chk_len(61);
    chk("frames_t1", frames_sent, 32'(model_frames));

    // Single order flushed by timeout
    ords = '{32'h005A800A};
    push_market(ords);
    write_order(32'h005A800A);
    k = 0;
    while (!m_axis_tvalid && k < 100) begin tick(); k++; end
    chk("timeout_latency", k, 21);
    wait_frames(2);
    chk_len(49);
    chk("frames_t2", frames_sent, 32'(model_frames));

    // Dump request with empty FIFO
    push_dump();
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    wait_frames(3);
    chk_len(46);
    chk("frames_t3", frames_sent, 32'(model_frames));

    // Flush and dump in the same cycle: orders first, then the dump
    ords = '{32'h00010001, 32'h00028002, 32'h00030003};
    push_market(ords);
    push_dump();
    foreach (ords[i]) write_order(ords[i]);
    chk("level_before_flush", fifo_level, 5'd3);
    flush_req = 1'b1; dump_req = 1'b1; tick(); flush_req = 1'b0; dump_req = 1'b0;
    wait_frames(5);
    chk_len(57);
    chk_len(46);
    chk("frames_t4", frames_sent, 32'(model_frames));

    // Random backpressure with 10 back-to-back writes: frames of 4, 4, then 2 by timeout
    for (int i = 0; i < 10; i++) bp_ords[i] = {16'(16'h0100 + i), 1'(i % 2), 1'b0, 14'(i + 3)};
    ords = '{bp_ords[0], bp_ords[1], bp_ords[2], bp_ords[3]};
    push_market(ords);
    ords = '{bp_ords[4], bp_ords[5], bp_ords[6], bp_ords[7]};
    push_market(ords);
    ords = '{bp_ords[8], bp_ords[9]};
    push_market(ords);
    bp_en = 1'b1;
    for (int i = 0; i < 10; i++) write_order(bp_ords[i]);
    wait_frames(8);
    bp_en = 1'b0;
    chk_len(61);
    chk_len(61);
    chk_len(53);
    chk("frames_bp", frames_sent, 32'(model_frames));
    chk("sb_empty_bp", exp_q.size(), 32'd0);
    chk("level_bp", fifo_level, 5'd0);
    repeat (2) tick();

    // Reset in the middle of a frame
    mon_quiet = 1'b1;
    ords = '{32'h11110001, 32'h22220002, 32'h33330003, 32'h44440004};
    foreach (ords[i]) write_order(ords[i]);
    k = 0;
    while (!m_axis_tvalid && k < 50) begin tick(); k++; end
    repeat (20) tick();
    chk("byte20_valid", m_axis_tvalid, 1'b1);
    rst_udp = 1'b1;
    tick();
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_tlast", m_axis_tlast, 1'b0);
    chk("midrst_level", fifo_level, 5'd0);
    chk("midrst_frames", frames_sent, 16'd0);
    rst_udp = 1'b0;
    model_frames = 0;
    tick();
    mon_quiet = 1'b0;
    chk("sready_after_midrst", s_order_tready, 1'b1);
    push_dump();
    target = frames_obs + 1;
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    wait_frames(target);
    chk_len(46);
    chk("frames_after_midrst", frames_sent, 16'd1);
    chk("sb_empty_end", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
